inv_bvurem_search: RTL and testbench
====================================

INV_BVUREM_SEARCH -- requirements
Module: inv_bvurem_search

Interface
REQ-001 SHALL have parameter W, default 4, operand/result bit width (W >= 2).
REQ-002 SHALL have parameter POS_DEFAULT, default 0: 0 = unknown x is dividend (x urem s), 1 = x is divisor (s urem x).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request a new search; sampled only in IDLE.
REQ-006 SHALL have port s, input, W, fixed operand; captured on accepted start.
REQ-007 SHALL have port t, input, W, bound; captured on accepted start.
REQ-008 SHALL have port pos, input, 1, operand position; present only with INV_POS_SEL_EN; captured on accepted start.
REQ-009 SHALL have port busy, output, 1, high while a search is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at search completion.
REQ-011 SHALL have port found, output, 1, witness exists; valid from done until next accepted start.
REQ-012 SHALL have port x, output, W, witness value; valid with found.

Function
REQ-013 SHALL solve: find the smallest unsigned x with (x urem s) >=u t (pos=0) or (s urem x) >=u t (pos=1).
REQ-014 SHALL use SMT-LIB semantics: a urem 0 = a.
REQ-015 SHALL implement FSM IDLE -> DIV -> CHECK -> (DIV | DONE) -> IDLE.
REQ-016 IDLE: start=1 captures s, t, pos; sets candidate to 0; moves to DIV; busy rises next cycle.
REQ-017 DIV SHALL be a restoring shift-subtract divider taking exactly W cycles per candidate, and SHALL produce the remainder only.
REQ-018 A zero divisor SHALL yield remainder = dividend through the same W-cycle datapath, with no special case.
REQ-019 CHECK, one cycle: if remainder >=u t, latch x = candidate and found=1, then go to DONE.
REQ-020 CHECK otherwise: if candidate = 2^W-1, latch found=0 and x=0, then go to DONE; else increment candidate and go to DIV.
REQ-021 DONE, one cycle: done=1 and busy=0; then go to IDLE.
REQ-022 Latency: with start in cycle 0 and the witness at candidate index k, done SHALL be high in cycle (k+1)(W+1)+1.
REQ-023 No-solution latency SHALL be 2^W(W+1)+1 cycles.
REQ-024 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-025 found and x SHALL hold their values from DONE until the next accepted start, then clear to 0 on that accept.
REQ-026 The candidate counter SHALL be W+1 bits wide internally so wrap-around from 2^W-1 is never taken.
REQ-027 All comparisons SHALL be unsigned at width W.

Reset
REQ-028 While rst_n=0, outputs SHALL be busy=0, done=0, found=0, x=0, state=IDLE, candidate=0, and captured operands=0, applied asynchronously.
REQ-029 Reset asserted mid-search SHALL abort immediately, with no done pulse.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-031 Macro INV_POS_SEL_EN defined: the pos port SHALL exist and select the operand position per search.
REQ-032 Macro INV_POS_SEL_EN undefined: the pos port SHALL be absent and the position SHALL be fixed to POS_DEFAULT.

Verification
REQ-033 W=4, pos=0, s=3, t=2, start at cycle 0 -> done at cycle 16, found=1, x=2.
REQ-034 W=4, pos=0, s=7, t=0 -> done at cycle 6, found=1, x=0.
REQ-035 W=4, pos=0, s=1, t=1 -> done at cycle 81, found=0, x=0, busy high cycles 1-80.
REQ-036 W=4, pos=0, s=0, t=15 -> done at cycle 81, found=1, x=15 (zero-divisor rule).
REQ-037 W=4, INV_POS_SEL_EN defined, pos=1: s=5, t=6 -> done at cycle 81, found=0; s=5, t=3 -> done at cycle 6, found=1, x=0.
REQ-038 W=4, pos=0, s=1, t=1, start at cycle 0; rst_n=0 at cycle 9 -> busy=0, found=0, x=0 within the same cycle, no done pulse.
REQ-039 W=4, pos=0, s=1, t=1, start at cycle 0; rst_n released at cycle 11 -> start at cycle 12 is accepted.
REQ-040 Random start pulses while busy -> no effect on the result or on done timing.

Source files
------------

// File: rtl/inv_bvurem_search.sv
// -----------------------------------------------------------------------------
// inv_bvurem_search
//
// Purpose: finds the smallest unsigned W-bit x such that
//    (x urem s) >=u t   when the position is 0 (x is the dividend), or
//    (s urem x) >=u t   when the position is 1 (x is the divisor).
// "a urem 0 = a" semantics. Candidates 0 .. 2^W-1 are tried in order. Each
// candidate costs W cycles in a restoring shift-subtract divider, plus one
// CHECK cycle.
//
// Configuration macro: INV_POS_SEL_EN
//    defined   -> a pos input selects the operand position for each search
//    undefined -> no pos port; the position is fixed by POS_DEFAULT
//
// Ports:
//    clk    in   clock; all state changes on the rising edge
//    rst_n  in   asynchronous active-low reset
//    start  in   start a search; sampled only in IDLE
//    s      in   W   fixed operand, captured when start is accepted
//    t      in   W   lower bound for the remainder, captured when start is accepted
//    pos    in   operand position (only with INV_POS_SEL_EN)
//    busy   out  high while a search is running
//    done   out  one-cycle pulse when a search completes
//    found  out  a witness exists; held until the next accepted start
//    x      out  W   witness value; valid together with found
// -----------------------------------------------------------------------------
module inv_bvurem_search #(
   parameter int W           = 4,
   parameter bit POS_DEFAULT = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
`ifdef INV_POS_SEL_EN
   input  logic         pos,
`endif
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [W-1:0] x
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_CHECK,
      S_DONE
   } state_e;

   state_e         state_q, state_d;
   logic [W:0]     cand_q,  cand_d;
   logic [W-1:0]   s_q,     s_d;
   logic [W-1:0]   t_q,     t_d;
   logic           pos_q,   pos_d;
   logic [W-1:0]   rem_q,   rem_d;
   logic [W-1:0]   dvd_q,   dvd_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic           busy_q,  busy_d;
   logic           done_q,  done_d;
   logic           found_q, found_d;
   logic [W-1:0]   x_q,     x_d;

   logic           pos_in;
   logic [W-1:0]   divisor;
   logic [W:0]     shifted;
   logic [W+1:0]   diff;
   logic [W-1:0]   rem_step;

`ifdef INV_POS_SEL_EN
   assign pos_in = pos;
`else
   assign pos_in = POS_DEFAULT;
`endif

   // One restoring step. A zero divisor never borrows, so the dividend bits
   // simply shift into the remainder and it ends up equal to the dividend.
   // The partial remainder never needs more than W bits: it is either below a
   // nonzero divisor, or, for a zero divisor, made of fewer than W dividend bits.
   always_comb begin
      divisor  = pos_q ? cand_q[W-1:0] : s_q;
      shifted  = {rem_q, dvd_q[W-1]};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      rem_step = diff[W+1] ? shifted[W-1:0] : diff[W-1:0];
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      s_d     = s_q;
      t_d     = t_q;
      pos_d   = pos_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      found_d = found_q;
      x_d     = x_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               s_d     = s;
               t_d     = t;
               pos_d   = pos_in;
               cand_d  = '0;
               found_d = 1'b0;
               x_d     = '0;
               rem_d   = '0;
               cnt_d   = '0;
               dvd_d   = pos_in ? s : '0;
               busy_d  = 1'b1;
               state_d = S_DIV;
            end
         end

         S_DIV: begin
            rem_d = rem_step;
            dvd_d = {dvd_q[W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (rem_q >= t_q) begin
               found_d = 1'b1;
               x_d     = cand_q[W-1:0];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (cand_q == {1'b0, {W{1'b1}}}) begin
               found_d = 1'b0;
               x_d     = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Reload the divider straight from the incremented candidate.
               cand_d  = cand_q + 1'b1;
               rem_d   = '0;
               cnt_d   = '0;
               dvd_d   = pos_q ? s_q : cand_d[W-1:0];
               state_d = S_DIV;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cand_q  <= '0;
         s_q     <= '0;
         t_q     <= '0;
         pos_q   <= 1'b0;
         rem_q   <= '0;
         dvd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         s_q     <= s_d;
         t_q     <= t_d;
         pos_q   <= pos_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         found_q <= found_d;
         x_q     <= x_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign found = found_q;
   assign x     = x_q;

endmodule

// File: tb/tb_inv_bvurem_search.sv
// -----------------------------------------------------------------------------
// tb_inv_bvurem_search
//
// Testbench for inv_bvurem_search at W=4. Each search pushes its expected
// completion cycle, found flag and witness onto a scoreboard. A negedge
// monitor then checks busy, done, found and x in every cycle against that
// entry. Also covers reset mid-search, restart after reset, and start noise
// applied while busy. Honours INV_POS_SEL_EN (pos port) when it is defined.
// -----------------------------------------------------------------------------
module tb_inv_bvurem_search;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] s;
   logic [W-1:0] t;
`ifdef INV_POS_SEL_EN
   logic         pos;
`endif
   logic         busy;
   logic         done;
   logic         found;
   logic [W-1:0] x;

   inv_bvurem_search #(.W(W), .POS_DEFAULT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .s     (s),
      .t     (t),
`ifdef INV_POS_SEL_EN
      .pos   (pos),
`endif
      .busy  (busy),
      .done  (done),
      .found (found),
      .x     (x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int c;
      int lat;
      bit f;
      int xv;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   hold_f   = 1'b0;
   int   hold_x   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Reference search, written directly from the urem definition.
   function automatic int model(input int sv, input int tv, input int pv,
                                output bit f, output int xv);
      int a, b, r;
      for (int c = 0; c < 2**W; c++) begin
         a = (pv != 0) ? sv : c;
         b = (pv != 0) ? c : sv;
         r = (b == 0) ? a : a % b;
         if (r >= tv) begin
            f  = 1'b1;
            xv = c;
            return (c + 1) * (W + 1) + 1;
         end
      end
      f  = 1'b0;
      xv = 0;
      return (2**W) * (W + 1) + 1;
   endfunction

   // Monitor: cycle n is the interval holding the n-th falling edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_busy",  busy,  0);
         check("rst_done",  done,  0);
         check("rst_found", found, 0);
         check("rst_x",     x,     0);
         hold_f = 1'b0;
         hold_x = 0;
         sb.delete();
      end else if (sb.size() > 0 && cyc > sb[0].c) begin
         if (cyc < sb[0].c + sb[0].lat) begin
            check("run_busy",  busy,  1);
            check("run_done",  done,  0);
            check("run_found", found, 0);
            check("run_x",     x,     0);
         end else begin
            check("done_pulse", done,  1);
            check("done_busy",  busy,  0);
            check("done_found", found, sb[0].f);
            check("done_x",     x,     sb[0].xv);
            hold_f = sb[0].f;
            hold_x = sb[0].xv;
            void'(sb.pop_front());
         end
      end else begin
         check("idle_busy",  busy,  0);
         check("idle_done",  done,  0);
         check("idle_found", found, hold_f);
         check("idle_x",     x,     hold_x);
      end
   end

   task automatic run(input int sv, input int tv, input int pv,
                      input bit ef, input int ex, input int lat, input bit noise);
      exp_t e;
      @(posedge clk); #2;
      start = 1'b1;
      s     = W'(sv);
      t     = W'(tv);
`ifdef INV_POS_SEL_EN
      pos   = pv[0];
`endif
      e.c   = cyc + 1;
      e.lat = lat;
      e.f   = ef;
      e.xv  = ex;
      sb.push_back(e);
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #2;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            s     = W'($urandom);
            t     = W'($urandom);
`ifdef INV_POS_SEL_EN
            pos   = 1'($urandom_range(0, 1));
`endif
         end else begin
            start = 1'b0;
         end
      end
      @(posedge clk); #2;
      start = 1'b0;
      check("sb_drain", sb.size(), 0);
   endtask

   task automatic run_model(input int sv, input int tv, input int pv, input bit noise);
      bit f;
      int xv, lat;
      lat = model(sv, tv, pv, f, xv);
      run(sv, tv, pv, f, xv, lat, noise);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst_n = 1'b0;
      start = 1'b0;
      s     = '0;
      t     = '0;
`ifdef INV_POS_SEL_EN
      pos   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed vectors, position 0
      run(3, 2,  0, 1'b1, 2,  16, 1'b0);
      run(7, 0,  0, 1'b1, 0,  6,  1'b0);
      run(1, 1,  0, 1'b0, 0,  81, 1'b0);
      run(0, 15, 0, 1'b1, 15, 81, 1'b0);

`ifdef INV_POS_SEL_EN
      run(5, 6, 1, 1'b0, 0, 81, 1'b0);
      run(5, 3, 1, 1'b1, 0, 6,  1'b0);
`endif

      // Reset in the middle of a search: abort with no done, then restart
      @(posedge clk); #2;
      start = 1'b1;
      s     = W'(1);
      t     = W'(1);
`ifdef INV_POS_SEL_EN
      pos   = 1'b0;
`endif
      e.c   = cyc + 1;
      e.lat = 81;
      e.f   = 1'b0;
      e.xv  = 0;
      sb.push_back(e);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #2;
         start = 1'b0;
      end
      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk); #2;
      end
      rst_n = 1'b1;
      run(7, 0, 0, 1'b1, 0, 6, 1'b0);

      // Model-checked searches with start and operand noise while busy
      run_model(3, 2, 0, 1'b1);
      run_model(6, 4, 0, 1'b1);
      run_model(9, 8, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         int pv;
`ifdef INV_POS_SEL_EN
         pv = int'($urandom_range(0, 1));
`else
         pv = 0;
`endif
         run_model(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), pv, 1'b1);
      end

      repeat (2) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
